// File: rtl/state_machine_pkg.sv
// rtl/state_machine_pkg.sv - shared types and reset constants for the adder control FSM
package state_machine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        ADD  = 2'b10,
        HOLD = 2'b11
    } state_t;

    localparam logic S_RST    = 1'b0;
    localparam logic COUT_RST = 1'b0;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - combinational 1-bit full adder
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of three single-bit operands.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/state_machine.sv
// rtl/state_machine.sv - sequenced registered 1-bit full adder with start/soft-reset control
module state_machine
    import state_machine_pkg::*;
(
    input  logic clk,
    input  logic NRST,
    input  logic start,
    input  logic rst,
    input  logic CIN,
    input  logic A,
    input  logic B,
    output logic S,
    output logic COUT
);

    state_t state_q;
    state_t state_d;

    logic a_q;
    logic b_q;
    logic c_q;

    logic capture_en;
    logic result_en;
    logic result_clr;

    logic fa_s;
    logic fa_cout;

    full_adder u_full_adder (
        .a    (a_q),
        .b    (b_q),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // State register; NRST forces IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes; soft rst overrides every state.
    always_comb begin
        state_d    = state_q;
        capture_en = 1'b0;
        result_en  = 1'b0;
        result_clr = 1'b0;
        if (rst) begin
            state_d    = IDLE;
            result_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    result_clr = 1'b1;
                    if (start) begin
                        capture_en = 1'b1;
                        state_d    = LOAD;
                    end
                end
                LOAD: begin
                    state_d = ADD;
                end
                ADD: begin
                    result_en = 1'b1;
                    state_d   = HOLD;
                end
                HOLD: begin
                    state_d = HOLD;
                end
                default: begin
                    result_clr = 1'b1;
                    state_d    = IDLE;
                end
            endcase
        end
    end

    // Operands are latched only on the accepted start edge.
    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            a_q <= 1'b0;
            b_q <= 1'b0;
            c_q <= 1'b0;
        end else if (capture_en) begin
            a_q <= A;
            b_q <= B;
            c_q <= CIN;
        end
    end

    // Result registers: cleared in IDLE or on rst, loaded from the adder in ADD, held otherwise.
    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            S    <= S_RST;
            COUT <= COUT_RST;
        end else if (result_clr) begin
            S    <= S_RST;
            COUT <= COUT_RST;
        end else if (result_en) begin
            S    <= fa_s;
            COUT <= fa_cout;
        end
    end

endmodule

// File: tb/tb_state_machine.sv
// tb/tb_state_machine.sv - self-checking bench for state_machine
module tb_state_machine;

    logic clk = 1'b0;
    logic NRST = 1'b0;
    logic start = 1'b0;
    logic rst = 1'b0;
    logic CIN = 1'b0;
    logic A = 1'b0;
    logic B = 1'b0;
    logic S;
    logic COUT;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Model: an accepted request produces A+B+CIN two edges later, kept until rst.
    bit       busy = 1'b0;
    int       cnt = 0;
    bit [1:0] res = 2'b00;
    bit       exp_s = 1'b0;
    bit       exp_c = 1'b0;

    state_machine dut (
        .clk   (clk),
        .NRST  (NRST),
        .start (start),
        .rst   (rst),
        .CIN   (CIN),
        .A     (A),
        .B     (B),
        .S     (S),
        .COUT  (COUT)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            busy  = 1'b0;
            cnt   = 0;
            exp_s = 1'b0;
            exp_c = 1'b0;
        end else if (rst) begin
            busy  = 1'b0;
            cnt   = 0;
            exp_s = 1'b0;
            exp_c = 1'b0;
        end else if (!busy) begin
            if (start) begin
                busy = 1'b1;
                cnt  = 2;
                res  = 2'(A) + 2'(B) + 2'(CIN);
            end
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                exp_s = res[0];
                exp_c = res[1];
            end
        end
    end

    always @(negedge clk) begin
        total_cnt++;
        if (S === exp_s && COUT === exp_c) begin
            pass_cnt++;
        end else begin
            $display("FAIL model_cmp t=%0t S/COUT got %b%b expected %b%b", $time, S, COUT, exp_s, exp_c);
        end
    end

    task automatic check(input string name, input logic es, input logic ec);
        total_cnt++;
        if (S === es && COUT === ec) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s S/COUT got %b%b expected %b%b", name, S, COUT, es, ec);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit [1:0] sum;
        bit a;
        bit b;
        bit c;

        #4;
        check("reset_hold", 1'b0, 1'b0);
        #6;
        NRST = 1'b1;
        step();
        check("idle_after_reset", 1'b0, 1'b0);

        A = 1'b1; B = 1'b0; CIN = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("latency_not_yet", 1'b0, 1'b0);
        step();
        check("add_101", 1'b0, 1'b1);
        A = 1'b0; CIN = 1'b0;
        step(); step(); step();
        check("hold_101", 1'b0, 1'b1);
        rst = 1'b1;
        step();
        check("rst_clears", 1'b0, 1'b0);

        start = 1'b1; A = 1'b1; B = 1'b1; CIN = 1'b0;
        step(); step();
        check("rst_and_start_idle", 1'b0, 1'b0);
        rst = 1'b0;
        step(); step(); step();
        check("add_110_after_rst", 1'b0, 1'b1);
        start = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; step();

        for (int i = 0; i < 8; i++) begin
            a = i[2]; b = i[1]; c = i[0];
            A = a; B = b; CIN = c; start = 1'b1;
            step();
            start = 1'b0;
            step(); step();
            sum = 2'(a) + 2'(b) + 2'(c);
            check($sformatf("truth_%0d%0d%0d", a, b, c), sum[0], sum[1]);
            rst = 1'b1; step(); rst = 1'b0; step();
        end

        A = 1'b1; B = 1'b1; CIN = 1'b1; start = 1'b1;
        step(); start = 1'b0; step(); step();
        check("add_111", 1'b1, 1'b1);
        rst = 1'b1; step(); rst = 1'b0; step();
        A = 1'b1; B = 1'b0; CIN = 1'b0; start = 1'b1;
        step(); start = 1'b0; step(); step();
        check("add_100", 1'b1, 1'b0);
        rst = 1'b1; step(); rst = 1'b0; step();

        A = 1'b1; B = 1'b0; CIN = 1'b1; start = 1'b1;
        step();
        start = 1'b0; A = 1'b0; B = 1'b1; CIN = 1'b0;
        step();
        A = 1'b1; B = 1'b1; CIN = 1'b1;
        step();
        check("toggle_captured", 1'b0, 1'b1);
        A = 1'b0; B = 1'b0; CIN = 1'b0; start = 1'b1;
        step(); step();
        check("toggle_hold", 1'b0, 1'b1);
        start = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; step();

        A = 1'b1; B = 1'b1; CIN = 1'b1; start = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        check("abort_in_add", 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check("abort_relaunch_load", 1'b0, 1'b0);
        step(); step();
        check("abort_relaunch_result", 1'b1, 1'b1);
        start = 1'b0;

        #2;
        NRST = 1'b0;
        #1;
        check("async_reset_mid_hold", 1'b0, 1'b0);
        step();
        NRST = 1'b1;
        step(); step();
        check("idle_after_async", 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
